// File: rtl/led_display_package.sv
// Shared types and helpers for the BCM LED panel scanner: FSM encoding,
// RAM address width and per-bitplane channel extraction.
package led_display_package;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } bcm_state_t;

    localparam int MAX_DEPTH  = 8;
    localparam int MAX_WORD_W = 6 * MAX_DEPTH;

    function automatic int ram_addr_width(input int num_rows, input int num_cols);
        return $clog2(num_rows / 2) + $clog2(num_cols);
    endfunction

    // Returns {rT,gT,bT,rB,gB,bB} bit b from a RAM word whose channels are
    // packed MSB-first, each depth bits wide (word zero-extended to MAX_WORD_W).
    function automatic logic [5:0] extract_plane(input logic [MAX_WORD_W-1:0] word,
                                                 input int depth, input int b);
        logic [5:0] bits;
        logic [5:0] idx;
        bits = '0;
        for (int k = 0; k < 6; k++) begin
            idx     = 6'(k * depth + b);
            bits[k] = word[idx];
        end
        return bits;
    endfunction

endpackage

// File: rtl/led_display_col_shifter.sv
// Column shifter: walks NUM_COLS slots of 2*CLK_DIV cycles, generates the
// panel shift clock and holds the six serial colour bits for each slot.
module led_display_col_shifter
    import led_display_package::*;
#(
    parameter int NUM_COLS     = 64,
    parameter int COLOUR_DEPTH = 4,
    parameter int CLK_DIV      = 1,
    parameter int PLW          = 2
) (
    input  logic                        clk_in,
    input  logic                        n_reset_in,
    input  logic                        start_in,
    input  logic [PLW-1:0]              plane_in,
    input  logic [6*COLOUR_DEPTH-1:0]   ram_data_in,
    output logic [$clog2(NUM_COLS)-1:0] col_out,
    output logic                        last_slot_out,
    output logic                        done_out,
    output logic                        bit_clk_out,
    output logic [5:0]                  colour_out
);

    localparam int CW  = $clog2(NUM_COLS);
    localparam int PHW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    logic           active_q, active_d;
    logic [CW-1:0]  col_q, col_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic [5:0]     colour_q, colour_d;
    logic           last_phase;
    logic           last_slot;

    assign last_phase = (phase_q == PHW'(2 * CLK_DIV - 1));
    assign last_slot  = (col_q == CW'(NUM_COLS - 1));

    always_comb begin
        active_d = active_q;
        col_d    = col_q;
        phase_d  = phase_q;
        colour_d = colour_q;
        if (start_in) begin
            active_d = 1'b1;
            col_d    = '0;
            phase_d  = '0;
        end else if (active_q) begin
            // RAM data for this column is valid only in the slot's first cycle
            if (phase_q == '0) begin
                colour_d = extract_plane(MAX_WORD_W'(ram_data_in), COLOUR_DEPTH, int'(plane_in));
            end
            if (last_phase) begin
                phase_d = '0;
                if (last_slot) begin
                    active_d = 1'b0;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                phase_d = phase_q + PHW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            active_q <= 1'b0;
            col_q    <= '0;
            phase_q  <= '0;
            colour_q <= '0;
        end else begin
            active_q <= active_d;
            col_q    <= col_d;
            phase_q  <= phase_d;
            colour_q <= colour_d;
        end
    end

    assign col_out       = col_q;
    assign last_slot_out = last_slot;
    assign done_out      = active_q && last_phase && last_slot;
    assign bit_clk_out   = active_q && (phase_q >= PHW'(CLK_DIV));
    assign colour_out    = colour_q;

endmodule

// File: rtl/led_display_bcm_scanner.sv
// HUB75-style panel scanner: reads a frame RAM row by row and displays each
// bitplane for a binary-weighted time, with brightness-scaled output enable.
module led_display_bcm_scanner
    import led_display_package::*;
#(
    parameter int NUM_COLS     = 64,
    parameter int NUM_ROWS     = 32,
    parameter int COLOUR_DEPTH = 4,
    parameter int CLK_DIV      = 1,
    parameter int LSB_CYCLES   = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int LATCH_CYCLES = 1
) (
    input  logic                                          clk_in,
    input  logic                                          n_reset_in,
    input  logic                                          enable_in,
    input  logic [7:0]                                    brightness_in,
    output logic                                          ram_en_out,
    output logic [ram_addr_width(NUM_ROWS, NUM_COLS)-1:0] ram_addr_out,
    input  logic [6*COLOUR_DEPTH-1:0]                     ram_data_in,
    output logic                                          red_top_out,
    output logic                                          green_top_out,
    output logic                                          blue_top_out,
    output logic                                          red_bot_out,
    output logic                                          green_bot_out,
    output logic                                          blue_bot_out,
    output logic                                          bit_clk_out,
    output logic                                          latch_out,
    output logic                                          oe_n_out,
    output logic [$clog2(NUM_ROWS/2)-1:0]                 row_address_out,
    output logic                                          frame_done_out,
    output logic                                          busy_out
);

    localparam int SCAN_ROWS = NUM_ROWS / 2;
    localparam int RW        = $clog2(SCAN_ROWS);
    localparam int CW        = $clog2(NUM_COLS);
    localparam int PLW       = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1;
    localparam int PW        = $clog2(LSB_CYCLES) + COLOUR_DEPTH + 9;

    bcm_state_t     state_q, state_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic [PLW-1:0] plane_q, plane_d;
    logic [7:0]     bri_q, bri_d;
    logic [RW-1:0]  row_disp_q, row_disp_d;

    logic [PW-1:0]  disp_len;
    logic [PW-1:0]  on_product;
    logic [PW-1:0]  on_cycles;
    logic           disp_last;
    logic           last_plane;
    logic           last_row;
    logic           frame_end;

    logic           shift_start;
    logic           shift_done;
    logic           shift_last_slot;
    logic [CW-1:0]  shift_col;
    logic [5:0]     colour;

    assign disp_len   = PW'(LSB_CYCLES) << plane_q;
    assign on_product = disp_len * (PW'(bri_q) + PW'(1));
    assign on_cycles  = on_product >> 8;
    assign disp_last  = (cnt_q == disp_len - PW'(1));
    assign last_plane = (plane_q == PLW'(COLOUR_DEPTH - 1));
    assign last_row   = (row_q == RW'(SCAN_ROWS - 1));
    assign frame_end  = (state_q == DISPLAY) && disp_last && last_plane && last_row;
    assign shift_start = (state_q == PREFETCH);

    led_display_col_shifter #(
        .NUM_COLS     (NUM_COLS),
        .COLOUR_DEPTH (COLOUR_DEPTH),
        .CLK_DIV      (CLK_DIV),
        .PLW          (PLW)
    ) u_col_shifter (
        .clk_in        (clk_in),
        .n_reset_in    (n_reset_in),
        .start_in      (shift_start),
        .plane_in      (plane_q),
        .ram_data_in   (ram_data_in),
        .col_out       (shift_col),
        .last_slot_out (shift_last_slot),
        .done_out      (shift_done),
        .bit_clk_out   (bit_clk_out),
        .colour_out    (colour)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        bri_d      = bri_q;
        row_disp_d = row_disp_q;
        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = PREFETCH;
                    bri_d   = brightness_in;
                end
            end
            PREFETCH: state_d = SHIFT;
            SHIFT: begin
                if (shift_done) begin
                    state_d    = BLANK;
                    row_disp_d = row_q;
                end
            end
            BLANK: begin
                if (cnt_q == PW'(BLANK_CYCLES - 1)) state_d = LATCH;
            end
            LATCH: begin
                if (cnt_q == PW'(LATCH_CYCLES - 1)) state_d = DISPLAY;
            end
            DISPLAY: begin
                if (disp_last) begin
                    state_d = PREFETCH;
                    if (last_plane) begin
                        plane_d = '0;
                        row_d   = last_row ? '0 : row_q + RW'(1);
                    end else begin
                        plane_d = plane_q + PLW'(1);
                    end
                    // Enable is only honoured at frame boundaries
                    if (frame_end) begin
                        bri_d = brightness_in;
                        if (!enable_in) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            bri_q      <= '0;
            row_disp_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            bri_q      <= bri_d;
            row_disp_q <= row_disp_d;
        end
    end

    assign ram_en_out      = (state_q == PREFETCH) || ((state_q == SHIFT) && !shift_last_slot);
    assign ram_addr_out    = {row_q, (state_q == SHIFT) ? shift_col + CW'(1) : CW'(0)};
    assign latch_out       = (state_q == LATCH);
    assign oe_n_out        = !((state_q == DISPLAY) && (cnt_q < on_cycles));
    assign row_address_out = row_disp_q;
    assign frame_done_out  = frame_end;
    assign busy_out        = (state_q != IDLE);

    assign {red_top_out, green_top_out, blue_top_out,
            red_bot_out, green_bot_out, blue_bot_out} = colour;

endmodule

// File: tb/tb_led_display_bcm_scanner.sv
// Randomised bench for the BCM scanner: a frame-timeline model predicts every
// output cycle by cycle; per-frame totals are also pinned to hand-computed values.
module tb_led_display_bcm_scanner;

    localparam int COLS      = 4;
    localparam int ROWS      = 4;
    localparam int CD        = 2;
    localparam int CDIV      = 1;
    localparam int LSB       = 4;
    localparam int BLK       = 2;
    localparam int LAT       = 1;
    localparam int SROWS     = ROWS / 2;
    localparam int SHIFT_LEN = 2 * COLS * CDIV;
    localparam int OVERHEAD  = 1 + SHIFT_LEN + BLK + LAT;
    localparam int ROW_LEN   = CD * OVERHEAD + LSB * ((1 << CD) - 1);
    localparam int FRAME_LEN = SROWS * ROW_LEN;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  brightness = 8'd255;
    logic        ram_en_out;
    logic [2:0]  ram_addr_out;
    logic [11:0] ram_q = '0;
    logic        red_top_out, green_top_out, blue_top_out;
    logic        red_bot_out, green_bot_out, blue_bot_out;
    logic        bit_clk_out, latch_out, oe_n_out;
    logic [0:0]  row_address_out;
    logic        frame_done_out, busy_out;

    logic [11:0] mem [0:7];
    logic        directed = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    led_display_bcm_scanner #(
        .NUM_COLS(COLS), .NUM_ROWS(ROWS), .COLOUR_DEPTH(CD), .CLK_DIV(CDIV),
        .LSB_CYCLES(LSB), .BLANK_CYCLES(BLK), .LATCH_CYCLES(LAT)
    ) dut (
        .clk_in(clk), .n_reset_in(n_reset), .enable_in(enable), .brightness_in(brightness),
        .ram_en_out(ram_en_out), .ram_addr_out(ram_addr_out), .ram_data_in(ram_q),
        .red_top_out(red_top_out), .green_top_out(green_top_out), .blue_top_out(blue_top_out),
        .red_bot_out(red_bot_out), .green_bot_out(green_bot_out), .blue_bot_out(blue_bot_out),
        .bit_clk_out(bit_clk_out), .latch_out(latch_out), .oe_n_out(oe_n_out),
        .row_address_out(row_address_out), .frame_done_out(frame_done_out), .busy_out(busy_out)
    );

    always @(posedge clk) begin
        if (ram_en_out) ram_q <= mem[ram_addr_out];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int seg_len(input int p);
        return OVERHEAD + (LSB << p);
    endfunction

    // Behavioural model + compare, evaluated once per cycle at the falling edge
    initial begin : monitor
        bit  run = 0, just_reset = 1, done_valid = 0, prev_bclk = 0;
        int  t = 0, bri_m = 0, disp_row_m = 0, cyc = 0, last_done = 0;
        int  rise = 0, oe_low = 0, red1 = 0;
        int  row, o, p, s, len, on, ch_val, exp_oe;
        bit  e_oe_n, e_latch, e_bclk, e_done, e_busy, e_en;
        int  e_addr;
        logic [5:0]  e_col;
        logic [11:0] word;
        forever begin
            @(negedge clk);
            cyc++;
            e_oe_n = 1; e_latch = 0; e_bclk = 0; e_done = 0; e_busy = 0; e_en = 0;
            e_addr = 0; row = 0; o = 0; p = 0; s = 0;
            if (run) begin
                row = t / ROW_LEN;
                o   = t % ROW_LEN;
                while (o >= seg_len(p)) begin
                    o -= seg_len(p);
                    p++;
                end
                len    = LSB << p;
                on     = (len * (bri_m + 1)) / 256;
                e_busy = 1;
                e_done = (t == FRAME_LEN - 1);
                if (o == 0) begin
                    e_en = 1; e_addr = row * COLS;
                end else if (o <= SHIFT_LEN) begin
                    s      = (o - 1) / (2 * CDIV);
                    e_bclk = ((o - 1) % (2 * CDIV)) >= CDIV;
                    e_en   = (s < COLS - 1);
                    e_addr = row * COLS + ((s + 1) % COLS);
                end
                e_latch = (o >= 1 + SHIFT_LEN + BLK) && (o < OVERHEAD);
                e_oe_n  = !((o >= OVERHEAD) && (o - OVERHEAD < on));
                if (o > SHIFT_LEN) disp_row_m = row;
            end
            chk("oe_n", oe_n_out, e_oe_n);
            chk("latch", latch_out, e_latch);
            chk("bit_clk", bit_clk_out, e_bclk);
            chk("frame_done", frame_done_out, e_done);
            chk("busy", busy_out, e_busy);
            chk("ram_en", ram_en_out, e_en);
            if (e_en) chk("ram_addr", ram_addr_out, e_addr);
            chk("row_address", row_address_out, disp_row_m);
            if (e_bclk) begin
                word = mem[row * COLS + s];
                for (int ch = 0; ch < 6; ch++) begin
                    ch_val = (int'(word) >> (CD * (5 - ch))) % (1 << CD);
                    e_col[5 - ch] = ((ch_val >> p) & 1) != 0;
                end
                chk("colour", {red_top_out, green_top_out, blue_top_out,
                               red_bot_out, green_bot_out, blue_bot_out}, e_col);
            end
            if (just_reset)
                chk("colour_after_reset", {red_top_out, green_top_out, blue_top_out,
                                           red_bot_out, green_bot_out, blue_bot_out}, 0);
            if (bit_clk_out && !prev_bclk) begin
                rise++;
                if (red_top_out) red1++;
            end
            prev_bclk = bit_clk_out;
            if (!oe_n_out) oe_low++;
            if (frame_done_out) begin
                done_cnt++;
                $display("frame %0d done at cycle %0d bri=%0d oe_low=%0d rises=%0d",
                         done_cnt, cyc, bri_m, oe_low, rise);
                if (done_valid) chk("frame_period", cyc - last_done, 72);
                last_done  = cyc;
                done_valid = 1;
            end
            if (run && t == FRAME_LEN - 1) begin
                chk("rises_per_frame", rise, 16);
                exp_oe = -1;
                case (bri_m)
                    255: exp_oe = 24;
                    127: exp_oe = 12;
                    0:   exp_oe = 0;
                    default: exp_oe = -1;
                endcase
                if (exp_oe >= 0) chk("oe_low_per_frame", oe_low, exp_oe);
                if (directed) chk("red_top_ones", red1, 4);
            end
            // advance model using the inputs the next rising edge will sample
            if (!n_reset) begin
                run = 0; t = 0; disp_row_m = 0; done_valid = 0; just_reset = 1;
            end else if (!run) begin
                done_valid = 0;
                if (enable) begin
                    run = 1; t = 0; bri_m = brightness; just_reset = 0;
                    rise = 0; oe_low = 0; red1 = 0;
                end
            end else if (t == FRAME_LEN - 1) begin
                bri_m = brightness;
                if (enable) begin
                    t = 0; rise = 0; oe_low = 0; red1 = 0;
                end else begin
                    run = 0; done_valid = 0;
                end
            end else begin
                t++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int n);
        int start;
        bit seen;
        for (int f = 0; f < n; f++) begin
            start = done_cnt;
            seen  = 0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(posedge clk);
                seen = (done_cnt != start);
            end
            if (!seen) begin
                $display("FAIL wait_frame: got no frame_done_out in 400 cycles, required one");
                $fatal(1, "timeout");
            end
        end
        #2;
    endtask

    initial begin : stimulus
        bit hit;
        for (int a = 0; a < 8; a++) mem[a] = (a < COLS) ? 12'h800 : 12'h000;
        directed = 1;
        cycles(3);
        n_reset = 1;
        cycles(2);

        enable = 1; brightness = 8'd255;
        wait_frames(3);
        brightness = 8'd127;
        wait_frames(3);
        brightness = 8'd0;
        wait_frames(2);

        for (int i = 0; i < 6; i++) begin
            cycles($urandom_range(1, 60));
            brightness = 8'($urandom);
        end

        wait_frames(1);
        cycles(5);
        enable = 0;
        wait_frames(1);
        cycles(4);
        directed = 0;
        for (int a = 0; a < 8; a++) mem[a] = 12'($urandom);
        brightness = 8'($urandom);
        enable = 1;
        wait_frames(2);

        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = bit_clk_out;
        end
        #1;
        n_reset = 0;
        cycles(1);
        n_reset = 1;
        wait_frames(2);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: brightness = 8'($urandom);
                4, 5, 6:    enable = 1'($urandom_range(0, 1));
                7: begin
                    n_reset = 0;
                    cycles(1);
                    n_reset = 1;
                end
                default: ;
            endcase
            cycles($urandom_range(1, 90));
        end
        enable = 1;
        brightness = 8'd255;
        wait_frames(3);
        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
